mips_multicycle_ctrl: RTL and testbench

//  Multi-cycle sequencer for the MIPS datapath: steps each instruction through FETCH/DECODE/EXEC/MEM/WB.

---
 rtl/mips_pkg.sv | 55 +++++
 rtl/mips_multicycle_ctrl_if.sv | 10 +
 rtl/mips_alu_decode.sv | 47 ++++
 rtl/mips_multicycle_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - opcode/funct, ALU code, mux select and state encodings for the multi-cycle controller
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_JR  = 6'b001000;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_ANDI = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_ADDI = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_LW   = 4'b1000;
  localparam logic [3:0] ALU_SW   = 4'b1001;
  localparam logic [3:0] ALU_BEQ  = 4'b1010;
  localparam logic [3:0] ALU_JAL  = 4'b1011;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_JR   = 4'b1111;

  localparam logic [1:0] PC_SRC_ALU    = 2'd0;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
  localparam logic [1:0] PC_SRC_REG    = 2'd3;

  localparam logic [1:0] SRCB_RT      = 2'd0;
  localparam logic [1:0] SRCB_FOUR    = 2'd1;
  localparam logic [1:0] SRCB_IMM     = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

  localparam logic [1:0] DST_RT = 2'd0;
  localparam logic [1:0] DST_RD = 2'd1;
  localparam logic [1:0] DST_RA = 2'd2;

  localparam logic [1:0] M2R_ALUOUT = 2'd0;
  localparam logic [1:0] M2R_MDR    = 2'd1;
  localparam logic [1:0] M2R_PC     = 2'd2;

  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC_R, EXEC_I, MEM_RD, MEM_WR,
    WB_R, WB_I, WB_LW, BRANCH, JUMP, HALT
  } state_t;

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// rtl/mips_multicycle_ctrl_if.sv - shared instruction/data memory port handshake
interface mips_multicycle_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic iord;
  logic mem_ready;

  modport master (output mem_req, output mem_we, output iord, input mem_ready);
  modport slave  (input mem_req, input mem_we, input iord, output mem_ready);
endinterface

// File: rtl/mips_alu_decode.sv
// rtl/mips_alu_decode.sv - {opcode,funct} to ALU control code, jr detect and legality
module mips_alu_decode
  import mips_pkg::*;
#(
  parameter int ALUC_W = 4
) (
  input  logic [5:0]        opcode,
  input  logic [5:0]        funct,
  output logic [ALUC_W-1:0] alu_ctrl,
  output logic              is_jr,
  output logic              is_legal
);

  logic [3:0] code;

  always_comb begin
    code     = ALU_AND;
    is_jr    = 1'b0;
    is_legal = 1'b1;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD: code = ALU_ADD;
          FN_SLL: code = ALU_SLL;
          FN_AND: code = ALU_AND;
          FN_NOR: code = ALU_NOR;
          FN_SLT: code = ALU_SLT;
          FN_JR: begin
            code  = ALU_JR;
            is_jr = 1'b1;
          end
          default: is_legal = 1'b0;
        endcase
      end
      OP_LW:   code = ALU_LW;
      OP_SW:   code = ALU_SW;
      OP_ADDI: code = ALU_ADDI;
      OP_ANDI: code = ALU_ANDI;
      OP_BEQ:  code = ALU_BEQ;
      OP_JAL:  code = ALU_JAL;
      default: is_legal = 1'b0;
    endcase
  end

  assign alu_ctrl = ALUC_W'(code);

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - multi-cycle MIPS sequencer with memory watchdog
// Optional ILLEGAL_TRAP_EN: unknown instructions set illegal and halt instead of acting as NOPs.
module mips_multicycle_ctrl
  import mips_pkg::*;
#(
  parameter int ALUC_W   = 4,
  parameter int WAIT_MAX = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [5:0]             opcode,
  input  logic [5:0]             funct,
  input  logic                   alu_zero,
  mips_multicycle_ctrl_if.master mem,
  output logic                   ir_write,
  output logic                   pc_write,
  output logic [1:0]             pc_src,
  output logic                   alu_src_a,
  output logic [1:0]             alu_src_b,
  output logic [ALUC_W-1:0]      alu_ctrl,
  output logic                   reg_write,
  output logic [1:0]             reg_dst,
  output logic [1:0]             mem_to_reg,
  output logic                   mem_err,
  output logic                   illegal
);

  localparam int CNT_W = $clog2(WAIT_MAX + 1);

`ifdef ILLEGAL_TRAP_EN
  localparam state_t ILLEGAL_NEXT = HALT;
`else
  localparam state_t ILLEGAL_NEXT = FETCH;
`endif

  state_t            state, state_next;
  logic              active;
  logic [5:0]        op_q, fn_q;
  logic [CNT_W-1:0]  wait_cnt;
  logic [ALUC_W-1:0] dec_alu_ctrl;
  logic              dec_is_jr, dec_is_legal;
  logic              wd_expire, illegal_hit;

  mips_alu_decode #(.ALUC_W(ALUC_W)) u_alu_decode (
    .opcode   (op_q),
    .funct    (fn_q),
    .alu_ctrl (dec_alu_ctrl),
    .is_jr    (dec_is_jr),
    .is_legal (dec_is_legal)
  );

  // active holds every output at 0 while in reset and for the edge that releases it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active   <= 1'b0;
      state    <= FETCH;
      op_q     <= '0;
      fn_q     <= '0;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      active <= 1'b1;
      if (active) state <= state_next;
      if (ir_write) begin
        op_q <= opcode;
        fn_q <= funct;
      end
      if (mem.mem_req) begin
        if (mem.mem_ready) wait_cnt <= '0;
        else if (wait_cnt != CNT_W'(WAIT_MAX)) wait_cnt <= wait_cnt + 1'b1;
      end
      if (wd_expire) mem_err <= 1'b1;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) illegal <= 1'b0;
    else if (illegal_hit) illegal <= 1'b1;
  end
`else
  assign illegal = 1'b0;
`endif

  always_comb begin
    state_next   = state;
    mem.mem_req  = 1'b0;
    mem.mem_we   = 1'b0;
    mem.iord     = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = PC_SRC_ALU;
    alu_src_a    = 1'b0;
    alu_src_b    = SRCB_RT;
    alu_ctrl     = ALUC_W'(ALU_AND);
    reg_write    = 1'b0;
    reg_dst      = DST_RT;
    mem_to_reg   = M2R_ALUOUT;
    illegal_hit  = 1'b0;
    wd_expire    = 1'b0;
    if (active) begin
      case (state)
        FETCH: begin
          mem.mem_req = 1'b1;
          alu_src_b   = SRCB_FOUR;
          alu_ctrl    = ALUC_W'(ALU_ADD);
          if (mem.mem_ready) begin
            ir_write   = 1'b1;
            pc_write   = 1'b1;
            state_next = DECODE;
          end
        end
        DECODE: begin
          alu_src_b = SRCB_IMM_SH2;
          alu_ctrl  = ALUC_W'(ALU_ADD);
          case (op_q)
            OP_RTYPE:                      state_next = EXEC_R;
            OP_LW, OP_SW, OP_ADDI, OP_ANDI: state_next = EXEC_I;
            OP_BEQ:                        state_next = BRANCH;
            OP_JAL:                        state_next = JUMP;
            default:                       illegal_hit = 1'b1;
          endcase
        end
        EXEC_R: begin
          alu_src_a = 1'b1;
          alu_ctrl  = dec_alu_ctrl;
          if (dec_is_jr) begin
            pc_write   = 1'b1;
            pc_src     = PC_SRC_REG;
            state_next = FETCH;
          end else if (!dec_is_legal) begin
            illegal_hit = 1'b1;
          end else begin
            state_next = WB_R;
          end
        end
        EXEC_I: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          alu_ctrl  = dec_alu_ctrl;
          case (op_q)
            OP_LW:   state_next = MEM_RD;
            OP_SW:   state_next = MEM_WR;
            default: state_next = WB_I;
          endcase
        end
        MEM_RD: begin
          mem.mem_req = 1'b1;
          mem.iord    = 1'b1;
          if (mem.mem_ready) state_next = WB_LW;
        end
        MEM_WR: begin
          mem.mem_req = 1'b1;
          mem.mem_we  = 1'b1;
          mem.iord    = 1'b1;
          if (mem.mem_ready) state_next = FETCH;
        end
        WB_R: begin
          reg_write  = 1'b1;
          reg_dst    = DST_RD;
          state_next = FETCH;
        end
        WB_I: begin
          reg_write  = 1'b1;
          state_next = FETCH;
        end
        WB_LW: begin
          reg_write  = 1'b1;
          mem_to_reg = M2R_MDR;
          state_next = FETCH;
        end
        BRANCH: begin
          alu_src_a  = 1'b1;
          alu_ctrl   = ALUC_W'(ALU_BEQ);
          pc_write   = alu_zero;
          pc_src     = PC_SRC_ALUOUT;
          state_next = FETCH;
        end
        JUMP: begin
          reg_write  = 1'b1;
          reg_dst    = DST_RA;
          mem_to_reg = M2R_PC;
          pc_write   = 1'b1;
          pc_src     = PC_SRC_JUMP;
          alu_ctrl   = ALUC_W'(ALU_JAL);
          state_next = FETCH;
        end
        default: ;
      endcase
      wd_expire = mem.mem_req && !mem.mem_ready && (wait_cnt == CNT_W'(WAIT_MAX - 1));
      if (illegal_hit) state_next = ILLEGAL_NEXT;
      if (wd_expire) state_next = HALT;
    end
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - directed vector bench for the multi-cycle MIPS controller
module tb_mips_multicycle_ctrl;

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        zero;
    logic        rdy;
    logic [20:0] exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic       alu_zero = 1'b0;
  logic       ir_write, pc_write, alu_src_a, reg_write, mem_err, illegal;
  logic [1:0] pc_src, alu_src_b, reg_dst, mem_to_reg;
  logic [3:0] alu_ctrl;

  int checks = 0;
  int errors = 0;

  vec_t  vecs[$];
  string names[$];

  mips_multicycle_ctrl_if mem_bus ();

  mips_multicycle_ctrl #(.ALUC_W(4), .WAIT_MAX(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .funct      (funct),
    .alu_zero   (alu_zero),
    .mem        (mem_bus),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_ctrl   (alu_ctrl),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .mem_err    (mem_err),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  wire [20:0] obs = {mem_bus.mem_req, mem_bus.mem_we, mem_bus.iord, ir_write, pc_write, pc_src,
                     alu_src_a, alu_src_b, alu_ctrl, reg_write, reg_dst, mem_to_reg, mem_err, illegal};

  function automatic logic [20:0] e(input logic req, input logic we, input logic io, input logic irw,
                                    input logic pcw, input logic [1:0] pcs, input logic sa,
                                    input logic [1:0] sb, input logic [3:0] alu, input logic rw,
                                    input logic [1:0] rd, input logic [1:0] m2r);
    return {req, we, io, irw, pcw, pcs, sa, sb, alu, rw, rd, m2r, 2'b00};
  endfunction

  function automatic logic [20:0] e_fetch(input logic rdy);
    return e(1, 0, 0, rdy, rdy, 2'd0, 0, 2'd1, 4'b0010, 0, 2'd0, 2'd0);
  endfunction

  function automatic logic [20:0] e_dec();
    return e(0, 0, 0, 0, 0, 2'd0, 0, 2'd3, 4'b0010, 0, 2'd0, 2'd0);
  endfunction

  task automatic addv(input string nm, input logic [5:0] op, input logic [5:0] fn,
                      input logic z, input logic rdy, input logic [20:0] ex);
    vec_t v;
    v.op = op; v.fn = fn; v.zero = z; v.rdy = rdy; v.exp = ex;
    vecs.push_back(v);
    names.push_back(nm);
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, want);
    end
  endtask

  task automatic step(input logic [5:0] op, input logic [5:0] fn, input logic z, input logic rdy);
    @(negedge clk);
    opcode = op; funct = fn; alu_zero = z; mem_bus.mem_ready = rdy;
    #1;
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("reset_pulse_outputs", 32'(obs), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    mem_bus.mem_ready = 1'b0;

    addv("add_fetch",  6'h00, 6'b100000, 0, 1, e_fetch(1));
    addv("add_decode", 6'h00, 6'b100000, 0, 1, e_dec());
    addv("add_exec",   6'h00, 6'b100000, 0, 1, e(0,0,0,0,0,2'd0,1,2'd0,4'b0010,0,2'd0,2'd0));
    addv("add_wb",     6'h00, 6'b100000, 0, 1, e(0,0,0,0,0,2'd0,0,2'd0,4'b0000,1,2'd1,2'd0));
    addv("lw_fetch",   6'b100011, 6'h00, 0, 1, e_fetch(1));
    addv("lw_decode",  6'b100011, 6'h00, 0, 1, e_dec());
    addv("lw_exec",    6'b100011, 6'h00, 0, 1, e(0,0,0,0,0,2'd0,1,2'd2,4'b1000,0,2'd0,2'd0));
    for (int i = 0; i < 3; i++)
      addv("lw_mem_wait", 6'b100011, 6'h00, 0, 0, e(1,0,1,0,0,2'd0,0,2'd0,4'b0000,0,2'd0,2'd0));
    addv("lw_mem_done", 6'b100011, 6'h00, 0, 1, e(1,0,1,0,0,2'd0,0,2'd0,4'b0000,0,2'd0,2'd0));
    addv("lw_wb",       6'b100011, 6'h00, 0, 1, e(0,0,0,0,0,2'd0,0,2'd0,4'b0000,1,2'd0,2'd1));
    addv("beq1_fetch",  6'b000100, 6'h00, 1, 1, e_fetch(1));
    addv("beq1_decode", 6'b000100, 6'h00, 1, 1, e_dec());
    addv("beq1_branch", 6'b000100, 6'h00, 1, 1, e(0,0,0,0,1,2'd1,1,2'd0,4'b1010,0,2'd0,2'd0));
    addv("beq0_fetch",  6'b000100, 6'h00, 0, 1, e_fetch(1));
    addv("beq0_decode", 6'b000100, 6'h00, 0, 1, e_dec());
    addv("beq0_branch", 6'b000100, 6'h00, 0, 1, e(0,0,0,0,0,2'd1,1,2'd0,4'b1010,0,2'd0,2'd0));
    addv("jal_fetch",   6'b000011, 6'h00, 0, 1, e_fetch(1));
    addv("jal_decode",  6'b000011, 6'h00, 0, 1, e_dec());
    addv("jal_jump",    6'b000011, 6'h00, 0, 1, e(0,0,0,0,1,2'd2,0,2'd0,4'b1011,1,2'd2,2'd2));
    addv("jr_fetch",    6'h00, 6'b001000, 0, 1, e_fetch(1));
    addv("jr_decode",   6'h00, 6'b001000, 0, 1, e_dec());
    addv("jr_exec",     6'h00, 6'b001000, 0, 1, e(0,0,0,0,1,2'd3,1,2'd0,4'b1111,0,2'd0,2'd0));
    addv("sw_fetch",    6'b101011, 6'h00, 0, 1, e_fetch(1));
    addv("sw_decode",   6'b101011, 6'h00, 0, 1, e_dec());
    addv("sw_exec",     6'b101011, 6'h00, 0, 1, e(0,0,0,0,0,2'd0,1,2'd2,4'b1001,0,2'd0,2'd0));
    addv("sw_mem",      6'b101011, 6'h00, 0, 1, e(1,1,1,0,0,2'd0,0,2'd0,4'b0000,0,2'd0,2'd0));
    addv("addi_fetch",  6'b001000, 6'h00, 0, 1, e_fetch(1));
    addv("addi_decode", 6'b001000, 6'h00, 0, 1, e_dec());
    addv("addi_exec",   6'b001000, 6'h00, 0, 1, e(0,0,0,0,0,2'd0,1,2'd2,4'b0011,0,2'd0,2'd0));
    addv("addi_wb",     6'b001000, 6'h00, 0, 1, e(0,0,0,0,0,2'd0,0,2'd0,4'b0000,1,2'd0,2'd0));
    addv("slt_fetch",   6'h00, 6'b101010, 0, 1, e_fetch(1));
    addv("slt_decode",  6'h00, 6'b101010, 0, 1, e_dec());
    addv("slt_exec",    6'h00, 6'b101010, 0, 1, e(0,0,0,0,0,2'd0,1,2'd0,4'b0111,0,2'd0,2'd0));
    addv("slt_wb",      6'h00, 6'b101010, 0, 1, e(0,0,0,0,0,2'd0,0,2'd0,4'b0000,1,2'd1,2'd0));
    addv("andi_fetch_wait", 6'b001100, 6'h00, 0, 0, e_fetch(0));
    addv("andi_fetch",  6'b001100, 6'h00, 0, 1, e_fetch(1));
    addv("andi_decode", 6'b001100, 6'h00, 0, 1, e_dec());
    addv("andi_exec",   6'b001100, 6'h00, 0, 1, e(0,0,0,0,0,2'd0,1,2'd2,4'b0001,0,2'd0,2'd0));
    addv("andi_wb",     6'b001100, 6'h00, 0, 1, e(0,0,0,0,0,2'd0,0,2'd0,4'b0000,1,2'd0,2'd0));
    addv("nor_fetch",   6'h00, 6'b100111, 0, 1, e_fetch(1));
    addv("nor_decode",  6'h00, 6'b100111, 0, 1, e_dec());
    addv("nor_exec",    6'h00, 6'b100111, 0, 1, e(0,0,0,0,0,2'd0,1,2'd0,4'b1100,0,2'd0,2'd0));
    addv("nor_wb",      6'h00, 6'b100111, 0, 1, e(0,0,0,0,0,2'd0,0,2'd0,4'b0000,1,2'd1,2'd0));

    // reset state, then release on a falling edge
    repeat (2) @(negedge clk);
    #1;
    chk("reset_outputs", 32'(obs), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("release_no_req", 32'(mem_bus.mem_req), 32'd0);

    foreach (vecs[i]) begin
      step(vecs[i].op, vecs[i].fn, vecs[i].zero, vecs[i].rdy);
      chk(names[i], 32'(obs), 32'(vecs[i].exp));
    end

    // reset in the middle of a stalled store
    step(6'b101011, 6'h00, 0, 1);
    step(6'b101011, 6'h00, 0, 1);
    step(6'b101011, 6'h00, 0, 1);
    step(6'b101011, 6'h00, 0, 0);
    chk("sw_stall_we", 32'({mem_bus.mem_req, mem_bus.mem_we}), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("sw_async_drop", 32'({mem_bus.mem_req, mem_bus.mem_we}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // opcode 111111
    step(6'b111111, 6'h00, 0, 1);
    chk("ill_fetch", 32'(obs), 32'(e_fetch(1)));
    step(6'b111111, 6'h00, 0, 1);
    chk("ill_decode", 32'(obs), 32'(e_dec()));
    step(6'b111111, 6'h00, 0, 1);
`ifdef ILLEGAL_TRAP_EN
    chk("ill_halt", 32'({mem_bus.mem_req, illegal}), 32'd1);
`else
    chk("ill_nop_fetch", 32'({mem_bus.mem_req, illegal}), 32'd2);
`endif
    reset_pulse();

    // watchdog: WAIT_MAX=4 wait cycles in FETCH
    for (int i = 0; i < 4; i++) begin
      step(6'h00, 6'b100000, 0, 0);
      chk("wd_waiting", 32'({mem_bus.mem_req, mem_err}), 32'd2);
    end
    step(6'h00, 6'b100000, 0, 0);
    chk("wd_expired", 32'({mem_bus.mem_req, mem_err}), 32'd1);
    step(6'h00, 6'b100000, 0, 1);
    chk("wd_halt_hold", 32'(obs), 32'(21'd2));
    reset_pulse();
    step(6'h00, 6'b100000, 0, 1);
    chk("wd_recover", 32'(obs), 32'(e_fetch(1)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
